// File: rtl/frequency_divider_multi_if.sv
// Control and status bundle for the multi-channel clock divider.
// The master drives enables, phase clear and terminal-count writes; the slave returns divided clocks, ticks and pending flags.
interface frequency_divider_multi_if #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 25,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]  en;
  logic             sync_clr;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [WIDTH-1:0] wr_data;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  pend;

  modport master (
    output en, sync_clr, wr_en, wr_ch, wr_data,
    input  clk_out, tick, pend
  );

  modport slave (
    input  en, sync_clr, wr_en, wr_ch, wr_data,
    output clk_out, tick, pend
  );
endinterface

// File: rtl/frequency_divider_multi.sv
// Multi-channel programmable 50%-duty clock divider with per-channel tick enables.
// Terminal-count writes to a running channel are held pending and applied only at a terminal, so no runt pulse is produced.
module frequency_divider_multi #(
  parameter int N_CH       = 4,
  parameter int WIDTH      = 25,
  parameter int DEFAULT_TC = 12499999,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  frequency_divider_multi_if.slave bus
);

  localparam logic [WIDTH-1:0] TC_RST = WIDTH'(DEFAULT_TC);

  logic [WIDTH-1:0] r_cnt     [N_CH];
  logic [WIDTH-1:0] r_tc      [N_CH];
  logic [WIDTH-1:0] r_pend_tc [N_CH];
  logic [N_CH-1:0]  r_clk_out;
  logic [N_CH-1:0]  r_tick;
  logic [N_CH-1:0]  r_pend;
  logic [N_CH-1:0]  w_wr_hit;

  // Channel select decoded as an integer, so addresses >= N_CH match nothing.
  always_comb begin
    // NOTE: default first so no path through the loop leaves a bit unassigned (no latch).
    w_wr_hit = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_wr_hit[i] = bus.wr_en && (int'(bus.wr_ch) == i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: these are a handful of flops, not a RAM, so every entry is reset explicitly.
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i]     <= '0;
        r_tc[i]      <= TC_RST;
        r_pend_tc[i] <= TC_RST;
      end
      r_clk_out <= '0;
      r_tick    <= '0;
      r_pend    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        // NOTE: non-blocking throughout, so every compare below sees the pre-edge values.
        if (bus.sync_clr || !bus.en[i]) begin
          r_cnt[i]     <= '0;
          r_clk_out[i] <= 1'b0;
          r_tick[i]    <= 1'b0;
          r_tc[i]      <= r_pend_tc[i];
          r_pend[i]    <= 1'b0;
        end else if (r_cnt[i] == r_tc[i]) begin
          // pend_tc equals tc whenever nothing is pending, so the copy is always safe here.
          r_cnt[i]     <= '0;
          r_clk_out[i] <= ~r_clk_out[i];
          r_tick[i]    <= ~r_clk_out[i];
          r_tc[i]      <= r_pend_tc[i];
          r_pend[i]    <= 1'b0;
        end else begin
          r_cnt[i]  <= r_cnt[i] + WIDTH'(1);
          r_tick[i] <= 1'b0;
        end

        // A write overrides the apply above: immediate when idle, otherwise deferred to the next terminal.
        if (w_wr_hit[i]) begin
          r_pend_tc[i] <= bus.wr_data;
          if (!bus.en[i]) begin
            r_tc[i] <= bus.wr_data;
          end else begin
            r_pend[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.clk_out = r_clk_out;
  assign bus.tick    = r_tick;
  assign bus.pend    = r_pend;

endmodule

// File: tb/tb_frequency_divider_multi.sv
// Directed bench for frequency_divider_multi: four channels, reset terminal count 3, 3-bit channel field.
// Output waveforms are captured as bit patterns (first sampled edge in the MSB) and compared with hand-derived values.
module tb_frequency_divider_multi;

  localparam int N_CH  = 4;
  localparam int WIDTH = 25;
  localparam int CH_W  = 3;

  logic clk;
  logic reset;

  frequency_divider_multi_if #(.N_CH(N_CH), .WIDTH(WIDTH), .CH_W(CH_W)) bus ();

  frequency_divider_multi #(
    .N_CH(N_CH), .WIDTH(WIDTH), .DEFAULT_TC(3), .CH_W(CH_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;

  logic [31:0] cap_co [N_CH];
  logic [31:0] cap_tk [N_CH];
  logic [31:0] cap_pd [N_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < N_CH; c++) begin
      cap_co[c] = '0;
      cap_tk[c] = '0;
      cap_pd[c] = '0;
    end
    for (int k = 0; k < n; k++) begin
      step();
      for (int c = 0; c < N_CH; c++) begin
        cap_co[c] = {cap_co[c][30:0], bus.clk_out[c]};
        cap_tk[c] = {cap_tk[c][30:0], bus.tick[c]};
        cap_pd[c] = {cap_pd[c][30:0], bus.pend[c]};
      end
    end
  endtask

  task automatic check_aligned(input string tag);
    check({tag, "_co0"}, cap_co[0], 32'b101010101010);
    check({tag, "_tk0"}, cap_tk[0], 32'b101010101010);
    check({tag, "_co1"}, cap_co[1], 32'b011001100110);
    check({tag, "_tk1"}, cap_tk[1], 32'b010001000100);
    check({tag, "_co2"}, cap_co[2], 32'b001110001110);
    check({tag, "_tk2"}, cap_tk[2], 32'b001000001000);
    check({tag, "_co3"}, cap_co[3], 32'b000011111000);
    check({tag, "_tk3"}, cap_tk[3], 32'b000010000000);
    for (int c = 0; c < N_CH; c++) check({tag, "_pd"}, cap_pd[c], 32'b0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    bus.en       = 4'b0001;
    bus.sync_clr = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_ch    = '0;
    bus.wr_data  = '0;

    // 1: reset state, then channel 0 alone at tc=3 (period 8)
    step();
    step();
    check("rst_clk_out", 32'(bus.clk_out), 32'b0);
    check("rst_tick",    32'(bus.tick),    32'b0);
    check("rst_pend",    32'(bus.pend),    32'b0);
    reset = 1'b1;
    capture(16);
    check("t1_co0",  cap_co[0], 32'b0001111000011110);
    check("t1_tk0",  cap_tk[0], 32'b0001000000010000);
    check("t1_pd0",  cap_pd[0], 32'b0);
    check("t1_co1",  cap_co[1], 32'b0);
    check("t1_co2",  cap_co[2], 32'b0);
    check("t1_co3",  cap_co[3], 32'b0);
    check("t1_tk13", cap_tk[1] | cap_tk[2] | cap_tk[3], 32'b0);

    // 2: idle-channel write is immediate; period 4 from the first enabled edge
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'd1;
    bus.wr_data = 25'd1;
    step();
    check("t2_pend_after_wr", 32'(bus.pend[1]), 32'b0);
    bus.wr_en = 1'b0;
    bus.en    = 4'b0011;
    capture(8);
    check("t2_co1", cap_co[1], 32'b01100110);
    check("t2_tk1", cap_tk[1], 32'b01000100);
    check("t2_pd1", cap_pd[1], 32'b0);

    // 3: running-channel write at cnt=1 is held until the terminal, then clk/2
    bus.en = 4'b0010;
    step();
    check("t3_disabled_co0", 32'(bus.clk_out[0]), 32'b0);
    bus.en = 4'b0011;
    step();
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'd0;
    bus.wr_data = 25'd0;
    step();
    check("t3_pend_set", 32'(bus.pend[0]), 32'b1);
    bus.wr_en = 1'b0;
    capture(6);
    check("t3_co0", cap_co[0], 32'b010101);
    check("t3_tk0", cap_tk[0], 32'b010101);
    check("t3_pd0", cap_pd[0], 32'b100000);

    // 4: tc = 0,1,2,4 on channels 0..3, phase-aligned by sync_clr
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'd2;
    bus.wr_data = 25'd2;
    step();
    bus.wr_ch   = 3'd3;
    bus.wr_data = 25'd4;
    step();
    bus.wr_en = 1'b0;
    check("t4_pend_idle_wr", 32'(bus.pend), 32'b0);
    bus.en = 4'b1111;
    for (int k = 0; k < 5; k++) step();
    bus.sync_clr = 1'b1;
    step();
    check("t4_clr_co", 32'(bus.clk_out), 32'b0);
    check("t4_clr_tk", 32'(bus.tick),    32'b0);
    bus.sync_clr = 1'b0;
    capture(12);
    check_aligned("t4");

    // 5: out-of-range write changes nothing; dropping en[2] mid-high forces it low
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'd4;
    bus.wr_data = 25'd7;
    step();
    bus.wr_en = 1'b0;
    check("t5_pend_oor", 32'(bus.pend), 32'b0);
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    capture(12);
    check_aligned("t5");
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("t5_co2_high", 32'(bus.clk_out[2]), 32'b1);
    bus.en = 4'b1011;
    capture(4);
    check("t5_co2_off", cap_co[2], 32'b0);
    check("t5_tk2_off", cap_tk[2], 32'b0);

    // 6: async reset mid-high-phase with a write pending, then defaults restored
    bus.en       = 4'b1111;
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    for (int k = 0; k < 5; k++) step();
    bus.wr_en   = 1'b1;
    bus.wr_ch   = 3'd3;
    bus.wr_data = 25'd9;
    step();
    bus.wr_en = 1'b0;
    check("t6_co3_high", 32'(bus.clk_out[3]), 32'b1);
    check("t6_pend3",    32'(bus.pend[3]),    32'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_co",   32'(bus.clk_out), 32'b0);
    check("t6_async_tk",   32'(bus.tick),    32'b0);
    check("t6_async_pend", 32'(bus.pend),    32'b0);
    #2;
    reset = 1'b1;
    capture(8);
    for (int c = 0; c < N_CH; c++) begin
      check("t6_co_default", cap_co[c], 32'b00011110);
      check("t6_tk_default", cap_tk[c], 32'b00010000);
      check("t6_pd_default", cap_pd[c], 32'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
